// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8-bit UART transmitter (start, 8 data LSB first, optional even parity, stop bits).
// Define UART_TX_PARITY_EN to include the parity slot and the ld strobe to the external parity_gen.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       parity_in,
  output logic       ld,
  output logic       tx,
  output logic       busy,
  output logic       done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic [7:0]  shreg, shreg_next;
  logic        tx_next, busy_next, done_next;
  logic        accept, bit_end;

  assign accept  = (state == IDLE) && tx_start;
  assign bit_end = (cnt == LAST_CNT);

  // parity_gen must load in the same cycle tx_data is captured, so the strobe
  // is decoded from the registered state rather than delayed by a flop.
`ifdef UART_TX_PARITY_EN
  assign ld = accept && !rst;
`else
  logic unused_parity_in;
  assign unused_parity_in = parity_in;
  assign ld = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational processes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shreg <= shreg_next;
      tx    <= tx_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // NOTE: each always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (tx_start) state_next = START;
      START:  if (bit_end) state_next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && idx == 3'd7) state_next = PARITY;
      PARITY: if (bit_end) state_next = STOP;
`else
      DATA:   if (bit_end && idx == 3'd7) state_next = STOP;
`endif
      STOP:   if (bit_end && idx == LAST_STOP) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered-output next values, all derived from state_next so
  // tx changes on the same edge as the state it belongs to.
  always_comb begin
    cnt_next   = cnt;
    idx_next   = idx;
    shreg_next = shreg;
    tx_next    = 1'b1;
    busy_next  = (state_next != IDLE);
    done_next  = (state == STOP) && (state_next == IDLE);

    if (state_next != state) begin
      cnt_next = '0;
      idx_next = '0;
    end else if (state != IDLE) begin
      cnt_next = bit_end ? 16'd0 : cnt + 16'd1;
      if (bit_end) idx_next = idx + 3'd1;
    end

    if (accept) shreg_next = tx_data;
    else if (state == DATA && bit_end) shreg_next = {1'b0, shreg[7:1]};

    case (state_next)
      IDLE:   tx_next = 1'b1;
      START:  tx_next = 1'b0;
      DATA:   tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      // The line register itself holds the parity bit captured on entry.
      PARITY: tx_next = (state == PARITY) ? tx : parity_in;
`endif
      STOP:   tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: two instances (16 clk/bit 1 stop, 4 clk/bit 2 stop)
// compared every cycle against a frame-slot model, plus literal frame checks.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int C0 = 16, S0 = 1, C1 = 4, S1 = 2;

  logic       clk = 1'b0;
  logic       rst, tx_start;
  logic [7:0] tx_data;
  logic [1:0] par, ld_w, tx_w, busy_w, done_w;
  logic [7:0] pg [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(C0), .STOP_BITS(S0)) dut0 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data), .parity_in(par[0]),
    .ld(ld_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  uart_tx_ctrl #(.CLKS_PER_BIT(C1), .STOP_BITS(S1)) dut1 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data), .parity_in(par[1]),
    .ld(ld_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  // External even-parity generator: loads on ld, holds otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) pg[i] <= 8'h00;
      else if (ld_w[i]) pg[i] <= tx_data;
    end
  end
  assign par[0] = ^pg[0];
  assign par[1] = ^pg[1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cpb(input int i);
    return (i == 0) ? C0 : C1;
  endfunction

  function automatic int flen(input int i);
    return (9 + P + ((i == 0) ? S0 : S1)) * cpb(i);
  endfunction

  // Frame model: position t (1..flen) within the frame maps to a slot of cpb cycles.
  bit         m_active [2];
  bit         m_done   [2];
  bit         m_par    [2];
  int         m_t      [2];
  logic [7:0] m_data   [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_done[i]   = 1'b0;
      m_t[i]      = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] = 1'b0;
        m_done[i]   = 1'b0;
      end else if (m_active[i]) begin
        if (m_t[i] == flen(i)) begin
          m_active[i] = 1'b0;
          m_done[i]   = 1'b1;
        end else begin
          m_t[i] = m_t[i] + 1;
        end
      end else begin
        m_done[i] = 1'b0;
        if (tx_start) begin
          m_active[i] = 1'b1;
          m_t[i]      = 1;
          m_data[i]   = tx_data;
          m_par[i]    = ^tx_data;
        end
      end
    end
  end

  function automatic logic exp_tx(input int i);
    int slot;
    if (!m_active[i]) return 1'b1;
    slot = (m_t[i] - 1) / cpb(i);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_data[i][slot-1];
    if (P == 1 && slot == 9) return m_par[i];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("tx%0d", i), 32'(tx_w[i]), 32'(exp_tx(i)));
        check($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_active[i]));
        check($sformatf("done%0d", i), 32'(done_w[i]), 32'(m_done[i]));
        check($sformatf("ld%0d", i), 32'(ld_w[i]),
              32'((P == 1) && !m_active[i] && tx_start && !rst));
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      ok = !m_active[0] && !m_active[1];
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // One-cycle start pulse; measures inst0 done latency, inst0 mid-slot tx values,
  // inst1 busy length and inst0 ld strobes over the frame.
  task automatic run_frame(input logic [7:0] b, output int d0, output int b1,
                           output logic [10:0] slots, output int ldn);
    int d1;
    wait_idle();
    @(posedge clk); #1;
    tx_start = 1'b1;
    tx_data  = b;
    @(negedge clk);
    ldn = int'(ld_w[0]);
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    d0 = 0; d1 = 0; b1 = 0; slots = '1;
    for (int k = 1; k <= 400 && (d0 == 0 || d1 == 0); k++) begin
      @(negedge clk);
      if (busy_w[0] && ((k - 1) % C0) == C0 / 2) slots[(k - 1) / C0] = tx_w[0];
      if (ld_w[0]) ldn++;
      if (busy_w[1]) b1++;
      if (done_w[0] && d0 == 0) d0 = k;
      if (done_w[1] && d1 == 0) d1 = k;
    end
    if (d0 == 0 || d1 == 0) check("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b1, ldn;
    logic [10:0] slots;
    bit seen;

    // Reset wins over a simultaneous start request.
    rst = 1'b1; tx_start = 1'b1; tx_data = 8'h5A;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_tx", 32'(tx_w), 32'b11);
    check("rst_busy", 32'(busy_w), 32'b00);
    check("rst_done", 32'(done_w), 32'b00);
    check("rst_ld", 32'(ld_w), 32'b00);
    @(posedge clk); #1;
    rst = 1'b0; tx_start = 1'b0;
    @(negedge clk);
    check("rst_nostart", 32'(busy_w), 32'b00);

    // 0xA5: slots 0,1,0,1,0,0,1,0,1,[parity 0],1
    run_frame(8'hA5, d0, b1, slots, ldn);
    check("a5_done_latency", 32'(d0 - 1), (P == 1) ? 32'd176 : 32'd160);
    check("a5_slots", 32'(slots), (P == 1) ? 32'b10101001010 : 32'b11101001010);
    check("a5_ld_count", 32'(ldn), 32'(P));
    check("a5_inst1_len", 32'(b1), (P == 1) ? 32'd48 : 32'd44);

    // 0x01: parity slot is 1 (stop slot is 1 as well without parity)
    run_frame(8'h01, d0, b1, slots, ldn);
    check("p01_slot9", 32'(slots[9]), 32'd1);
    check("p01_bit0", 32'(slots[1]), 32'd1);
    check("p01_ld_count", 32'(ldn), 32'(P));

    // 0x80 on the 4 clk/bit, 2-stop instance
    run_frame(8'h80, d0, b1, slots, ldn);
    check("p80_inst1_len", 32'(b1), (P == 1) ? 32'd48 : 32'd44);

    // Back-to-back: start held high through the first frame and its done cycle.
    wait_idle();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_data = 8'h3C;
    @(posedge clk); #1;
    tx_data = 8'hC3;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = done_w[0];
    end
    check("b2b_done_seen", 32'(seen), 32'd1);
    check("b2b_done_busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    check("b2b_start_bit", {30'd0, busy_w[0], tx_w[0]}, 32'b10);
    @(posedge clk); #1;
    tx_start = 1'b0;

    // Reset 50 cycles into a 0x55 frame, then a clean 0x55 frame.
    wait_idle();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_data = 8'h55;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (49) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", 32'(tx_w[0]), 32'd1);
    check("abort_busy", 32'(busy_w[0]), 32'd0);
    check("abort_done", 32'(done_w[0]), 32'd0);
    run_frame(8'h55, d0, b1, slots, ldn);
    check("p55_done_latency", 32'(d0 - 1), (P == 1) ? 32'd176 : 32'd160);
    check("p55_slots", 32'(slots), (P == 1) ? 32'b10010101010 : 32'b11010101010);

    // Random traffic: rare resets, frequent start requests, data churning every cycle.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      rst      = ($urandom_range(0, 799) == 0);
      tx_start = ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0; tx_start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits (1 or 2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_start  input  1  request to send tx_data; level-sampled in IDLE.
REQ-006 SHALL have port tx_data  input  8  byte to send; also wired externally to parity_gen data.
REQ-007 SHALL have port parity_in  input  1  even-parity bit from parity_gen out.
REQ-008 SHALL have port ld  output  1  load strobe to parity_gen ld.
REQ-009 SHALL have port tx  output  1  serial line; idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-013 In IDLE with tx_start=1, SHALL capture tx_data into an 8-bit shift register, pulse ld=1 for that cycle only, and enter START next cycle.
REQ-014 tx_start while not in IDLE SHALL be ignored; no queueing.
REQ-015 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after acceptance.
REQ-016 DATA SHALL shift out 8 bits LSB first, each held for exactly CLKS_PER_BIT cycles; 3-bit index 0..7, leave DATA after index 7 expires.
REQ-017 PARITY SHALL register parity_in on entry and drive it for CLKS_PER_BIT cycles; parity_gen holds its value because ld is low.
REQ-018 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 Bit-period counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, reset to 0 on every state change; no wrap-around carry into the next bit.
REQ-020 busy SHALL be 1 from the cycle after acceptance through the final STOP cycle; 0 in IDLE.
REQ-021 done SHALL pulse 1 for the first IDLE cycle after STOP, with busy=0 in that cycle.
REQ-022 tx_start=1 in the done cycle SHALL be accepted (back-to-back frames, zero idle gap beyond that one cycle).
REQ-023 tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-024 Total frame length SHALL be (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, P=1 with parity, 0 without.

Reset
REQ-025 rst=1 SHALL force, at the next edge: state IDLE, tx=1, busy=0, done=0, ld=0, counters and shift register 0.
REQ-026 rst asserted mid-frame SHALL abort the frame without a done pulse; tx returns high the cycle after rst is sampled.
REQ-027 rst and tx_start in the same cycle: rst SHALL win; no frame started.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: PARITY state present, frame 8E1 (or 8E2), ld driven as REQ-013.
REQ-029 Macro UART_TX_PARITY_EN undefined: PARITY state, parity_in usage removed; DATA goes directly to STOP; ld tied 0; parity_in unused.

Verification
REQ-030 Parity on, CLKS_PER_BIT=16, tx_data=0xA5 -> tx: 0 x16, then 1,0,1,0,0,1,0,1 x16 each, parity 0 x16, 1 x16; done 176 cycles after acceptance.
REQ-031 Parity on, tx_data=0x01 -> parity bit 1; ld high exactly one cycle, at acceptance.
REQ-032 Parity off, tx_data=0xFF -> 160-cycle frame, no parity slot, ld never high.
REQ-033 Two frames 0x3C then 0xC3, second tx_start held through done -> second start bit begins the cycle after done; tx_start pulses during busy ignored.
REQ-034 rst at cycle 50 of a 0x55 frame -> tx=1, busy=0 next cycle, no done; new 0x55 frame afterwards is correct.
REQ-035 STOP_BITS=2, CLKS_PER_BIT=4, tx_data=0x80 -> stop high for 8 cycles; total 48 cycles with parity.
